// File: rtl/computation_sequencer.sv
// Host-side sequencer for computation_module: store strobe, optional gap, then one
// compute strobe held until its done, with result capture, cycle count and timeout.
module computation_sequencer #(
  parameter int GAP     = 3,
  parameter int TIMEOUT = 63,
  parameter int DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          active_store,
  output logic          active_single,
  output logic          active_sa3,
  output logic          active_sa2,
  input  logic          done_single,
  input  logic          done_sa3,
  input  logic          done_sa2,
  input  logic [DW-1:0] c11,
  input  logic [DW-1:0] c12,
  input  logic [DW-1:0] c21,
  input  logic [DW-1:0] c22,
  output logic [DW-1:0] r11,
  output logic [DW-1:0] r12,
  output logic [DW-1:0] r21,
  output logic [DW-1:0] r22,
  output logic          result_valid,
  output logic          error,
  output logic [7:0]    run_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STORE,
    S_GAP,
    S_RUN
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [7:0] RUN_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     next_state;
  logic [1:0] mode_q;
  logic [3:0] gap_cnt;
  logic [7:0] run_cnt;
  logic       done_sel;
  logic       capture;
  logic       fire_error;
  logic       accept;

  // Only the done flag belonging to the latched mode can end a run.
  always_comb begin
    done_sel = 1'b0;
    case (mode_q)
      2'd0:    done_sel = done_single;
      2'd1:    done_sel = done_sa3;
      2'd2:    done_sel = done_sa2;
      default: done_sel = 1'b0;
    endcase
  end

  always_comb begin
    next_state = state;
    capture    = 1'b0;
    fire_error = 1'b0;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (mode != 2'd3) begin
            accept     = 1'b1;
            next_state = S_STORE;
          end else begin
            fire_error = 1'b1;
          end
        end
      end
      S_STORE: begin
        next_state = (GAP > 0) ? S_GAP : S_RUN;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        // A done on the timeout cycle still counts as success.
        if (done_sel) begin
          capture    = 1'b1;
          next_state = S_IDLE;
        end else if (run_cnt == RUN_LAST) begin
          fire_error = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      mode_q        <= 2'd0;
      gap_cnt       <= 4'd0;
      run_cnt       <= 8'd0;
      busy          <= 1'b0;
      active_store  <= 1'b0;
      active_single <= 1'b0;
      active_sa3    <= 1'b0;
      active_sa2    <= 1'b0;
      result_valid  <= 1'b0;
      error         <= 1'b0;
      run_cycles    <= 8'd0;
      r11           <= '0;
      r12           <= '0;
      r21           <= '0;
      r22           <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        mode_q <= mode;
      end
      if (state != S_GAP) begin
        gap_cnt <= 4'd0;
      end else begin
        gap_cnt <= gap_cnt + 4'd1;
      end
      if (state != S_RUN) begin
        run_cnt <= 8'd0;
      end else if (run_cnt != 8'hFF) begin
        run_cnt <= run_cnt + 8'd1;
      end
      busy          <= (next_state != S_IDLE);
      active_store  <= (next_state == S_STORE);
      active_single <= (next_state == S_RUN) && (mode_q == 2'd0);
      active_sa3    <= (next_state == S_RUN) && (mode_q == 2'd1);
      active_sa2    <= (next_state == S_RUN) && (mode_q == 2'd2);
      result_valid  <= capture;
      error         <= fire_error;
      if (capture) begin
        r11        <= c11;
        r12        <= c12;
        r21        <= c21;
        r22        <= c22;
        run_cycles <= run_cnt + 8'd1;
      end
    end
  end

endmodule

// File: doc/computation_sequencer.md
Name: computation_sequencer

Overview:
- Host-side initiator for computation_module. It issues the active_store / active_single / active_sa3 / active_sa2 handshake on request.
- It holds the selected compute strobe until the matching done arrives, then captures c11..c22 into result registers.
- It sits between the top-level control logic and computation_module, replacing hand-driven strobe sequencing.
- It adds a per-run cycle count and a timeout/error path.

Parameters:
- GAP, 3: idle cycles between the active_store cycle and the first compute-strobe cycle. Range 0..15.
- TIMEOUT, 63: maximum number of cycles the compute strobe stays high without a done. Range 1..255.
- DW, 8: data width of the c inputs and r outputs.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request pulse. Accepted only in IDLE.
- mode  in  2  compute mode, sampled with start: 0 single, 1 sa3, 2 sa2, 3 reserved.
- busy  out  1  high whenever state != IDLE.
- active_store  out  1  store strobe to computation_module.
- active_single  out  1  compute strobe for mode 0.
- active_sa3  out  1  compute strobe for mode 1.
- active_sa2  out  1  compute strobe for mode 2.
- done_single  in  1  completion flag for mode 0.
- done_sa3  in  1  completion flag for mode 1.
- done_sa2  in  1  completion flag for mode 2.
- c11, c12, c21, c22  in  DW each  result matrix from computation_module.
- r11, r12, r21, r22  out  DW each  captured results.
- result_valid  out  1  one-cycle pulse: the r outputs were updated.
- error  out  1  one-cycle pulse: reserved mode requested, or timeout.
- run_cycles  out  8  strobe-high cycle count of the last successful run.

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset: all outputs are 0, state is IDLE, internal counters are 0. Reset asserted mid-run aborts immediately: strobes are low in the cycle after the reset edge, there is no result_valid and no error.
- All outputs are registered.

State machine (IDLE, STORE, GAP, RUN):
- IDLE:
  - start=1 and mode<3: latch mode, go to STORE.
  - start=1 and mode=3: pulse error next cycle, stay in IDLE.
  - start=0: stay in IDLE.
- STORE: active_store=1 for exactly one cycle.
  - GAP>0: go to GAP with the gap counter cleared.
  - GAP=0: go directly to RUN.
- GAP: all strobes low for GAP cycles, then go to RUN. The run counter is cleared on entry to RUN.
- RUN:
  - Only the strobe for the latched mode is high. It stays high continuously, including the cycle in which its done is sampled.
  - The run counter increments every RUN cycle and saturates at 255.
  - On the edge where the matching done=1:
    - r11..r22 <= c11..c22.
    - run_cycles <= run counter + 1.
    - result_valid=1 for the next cycle.
    - Go to IDLE, so the strobe is low in that next cycle.
  - If done is not seen and the run counter reaches TIMEOUT-1 (strobe high for TIMEOUT cycles): pulse error, go to IDLE. r and run_cycles keep their previous values.
  - Done flags of non-selected modes are ignored.

Timing and boundary rules:
- Latency: start sampled at edge k gives:
  - active_store high in cycle k+1;
  - gap cycles k+2 .. k+1+GAP;
  - compute strobe high from cycle k+2+GAP.
- start while busy is ignored; no queueing.
- Done in the first RUN cycle: run_cycles=1.
- Done in the same cycle as the timeout limit: done wins (capture, no error).
- A done that arrives in IDLE, STORE or GAP is ignored.
- At most one of the four strobes is high in any cycle.
- busy deasserts in the same cycle result_valid or the timeout error pulses. A new start is accepted in that cycle.

Test Plan:
- Reset, then start with mode=0. The model asserts done_single on the 37th strobe cycle with c=36,54,36,54 -> active_store one cycle, 3 gap cycles, active_single high for exactly 37 cycles, then r11=36, r12=54, r21=36, r22=54, run_cycles=37, one result_valid pulse.
- Back-to-back runs, mode=1 (done on cycle 17) then mode=2 (done on cycle 29). The second start is issued in the cycle busy falls -> active_sa3 high 17 cycles, then active_sa2 high 29 cycles, run_cycles=17 then 29, never two strobes high together.
- mode=0, no done ever -> active_single high exactly 63 cycles, then error pulse, busy=0. r keeps the previous values; result_valid stays 0.
- start with mode=3 -> error pulse one cycle later, busy stays 0, no strobes. Also: a start pulse during RUN -> ignored, the current run completes unchanged.
- rst asserted on the 10th RUN cycle of mode=2 -> active_sa2=0 next cycle, all outputs 0. A following mode=1 run completes normally.
- done_sa2 pulsed while mode=0 is running, and done_single pulsed during GAP -> both ignored; the run completes only on a done_single seen in RUN.
